// File: rtl/unidad_busqueda_if.sv
// Instruction-memory fetch bus: request/address out, acknowledge/data back.
interface unidad_busqueda_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/unidad_busqueda.sv
// Fetch stage: owns the PC, fetches words over a req/ack bus and holds them for decode.
// Optional fetch timeout (sticky err_fetch, NOP injection) enabled by defining FETCH_TIMEOUT_EN.
module unidad_busqueda #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      avanza,
  input  logic                      SaltoCond,
  input  logic                      oZero,
  input  logic [31:0]               extSigno,
  unidad_busqueda_if.master         bus,
  output logic [31:0]               instru,
  output logic                      instru_valid,
  output logic [31:0]               pc,
  output logic [31:0]               pc_mas4,
  output logic                      err_fetch
);

  localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

  if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
    $error("unidad_busqueda: TIMEOUT_CYC must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] pc_r;
  logic [31:0] instru_r;
  logic [31:0] next_pc_s;
  logic        capture_s;
  logic        load_nop_s;
  logic        pc_upd_s;
  logic        timeout_s;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_r;
  logic       err_r;

  // Timeout fires on the TIMEOUT_CYC-th consecutive WAIT cycle
  always_comb begin
    timeout_s = (cnt_r == TO_LAST);
  end

  // WAIT-cycle counter (zero on every entry into WAIT) and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
      err_r <= 1'b0;
    end else begin
      if (state_r == WAIT) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= 8'd0;
      end
      if (load_nop_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign err_fetch = err_r;
`else
  // Without the timeout, WAIT only ends on an acknowledge
  always_comb begin
    timeout_s = 1'b0;
  end

  assign err_fetch = 1'b0;
`endif

  // Sequential or taken-branch target; the shift keeps target bits [1:0] at zero
  always_comb begin
    if (SaltoCond && oZero) begin
      next_pc_s = pc_mas4 + (extSigno << 2);
    end else begin
      next_pc_s = pc_mas4;
    end
  end

  // Next-state and datapath strobes; an ack beats a simultaneous timeout
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    load_nop_s   = 1'b0;
    pc_upd_s     = 1'b0;
    case (state_r)
      IDLE: begin
        next_state_s = WAIT;
      end
      WAIT: begin
        if (bus.mem_ack) begin
          capture_s    = 1'b1;
          next_state_s = VALID;
        end else if (timeout_s) begin
          load_nop_s   = 1'b1;
          next_state_s = VALID;
        end else begin
          next_state_s = WAIT;
        end
      end
      VALID: begin
        if (avanza) begin
          pc_upd_s     = 1'b1;
          next_state_s = WAIT;
        end else begin
          next_state_s = VALID;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, PC and held instruction registers; reset overrides ack and avanza
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC_AL;
      instru_r <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      if (pc_upd_s) begin
        pc_r <= next_pc_s;
      end
      if (capture_s) begin
        instru_r <= bus.mem_rdata;
      end else if (load_nop_s) begin
        instru_r <= 32'h0000_0000;
      end
    end
  end

  assign pc           = pc_r;
  assign pc_mas4      = pc_r + 32'd4;
  assign instru       = instru_r;
  assign instru_valid = (state_r == VALID);
  assign bus.mem_req  = (state_r == WAIT);
  assign bus.mem_addr = pc_r;

endmodule
